// File: rtl/decoder_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decoder_seq_pkg
// Purpose  : Shared types and constants for the decoder select sequencer.
//            FSM state encoding, code width and count, direction values,
//            and a helper that steps a code by +/-1 modulo NUM_CODES.
// Revision : 1.0 - initial release
// ============================================================================
package decoder_seq_pkg;

  localparam int CODE_W    = 3;
  localparam int NUM_CODES = 8;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Natural 3-bit wrap provides the modulo-8 behaviour in both directions.
  function automatic logic [CODE_W-1:0] next_code(input logic [CODE_W-1:0] code,
                                                  input logic              dir);
    return (dir == DIR_DOWN) ? code - 3'd1 : code + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_select_sequencer_dwell_counter.sv
`default_nettype none
// ============================================================================
// Module   : dwell_counter
// Purpose  : Counts 0..DWELL-1 while enabled and flags the last dwell cycle.
// Ports    : clk    - rising-edge clock
//            rst    - synchronous active-high reset
//            clr    - synchronous clear back to 0
//            en     - count enable
//            expire - high during the last cycle of the dwell (combinational
//                     decode of the count, consumed only by the parent FSM)
// Revision : 1.0 - initial release
// ============================================================================
module dwell_counter #(
  parameter int CNT_W = 8,
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign expire = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = expire ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/decoder_select_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : decoder_select_sequencer
// Purpose  : Steps a 3-bit select code {a,b,c} through all 8 codes, holding
//            each for DWELL cycles, to drive a 3-to-8 decoder.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            start, stop, dir   - launch / abort / direction (0 up, 1 down)
//            a, b, c            - registered select code (a = MSB)
//            valid, busy, done  - registered status; done is a 1-cycle pulse
// Config   : DECODER_SEQ_LOOP_EN - when defined, the sequence wraps back to
//            START_CODE after the 8th code and runs until stop/rst, pulsing
//            done on the first cycle of each new lap.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_select_sequencer
  import decoder_seq_pkg::*;
#(
  parameter int DWELL      = 4,
  parameter int CNT_W      = 8,
  parameter int START_CODE = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic stop,
  input  logic dir,
  output logic a,
  output logic b,
  output logic c,
  output logic valid,
  output logic busy,
  output logic done
);

  localparam logic [CODE_W-1:0] START    = START_CODE[CODE_W-1:0];
  localparam logic [CODE_W-1:0] LAST_STEP = CODE_W'(NUM_CODES - 1);

  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_q,  code_d;
  logic [CODE_W-1:0] step_q,  step_d;
  logic              dir_q,   dir_d;
  logic              valid_q, valid_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  logic in_run;
  logic expire;

  assign in_run = (state_q == RUN);

  // Counter is held at 0 outside RUN so each pass starts with a full dwell;
  // clearing on stop keeps it aligned even though the FSM also leaves RUN.
  dwell_counter #(
    .CNT_W (CNT_W),
    .DWELL (DWELL)
  ) u_dwell (
    .clk    (clk),
    .rst    (rst),
    .clr    (!in_run || stop),
    .en     (in_run),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    step_d  = step_q;
    dir_d   = dir_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          code_d  = START;
          step_d  = '0;
          dir_d   = dir;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        if (stop) begin
          state_d = IDLE;
          code_d  = '0;
          step_d  = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (expire) begin
          if (step_q == LAST_STEP) begin
`ifdef DECODER_SEQ_LOOP_EN
            // New lap: done lands on the first cycle of the restarted code.
            code_d = START;
            step_d = '0;
            done_d = 1'b1;
`else
            state_d = DONE;
            code_d  = '0;
            step_d  = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end else begin
            code_d = next_code(code_q, dir_q);
            step_d = step_q + 1'b1;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        code_d  = '0;
        step_d  = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      step_q  <= '0;
      dir_q   <= DIR_UP;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a     = code_q[2];
  assign b     = code_q[1];
  assign c     = code_q[0];
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
`default_nettype wire
